// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle between a requester and the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b one bit per clock, LSB first,
// full subtractor built from two half subtractors.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             bq_q, bq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic x, y, bin, d1, b1, d, b2, bout;

  // Full subtractor on the current LSBs: HS1 on (x, y), HS2 on (d1, bin)
  always_comb begin
    x    = sa_q[0];
    y    = sb_q[0];
    bin  = bq_q;
    d1   = x ^ y;
    b1   = ~x & y;
    d    = d1 ^ bin;
    b2   = ~d1 & bin;
    bout = b1 | b2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      bq_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      bq_q     <= bq_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    bq_d     = bq_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          bq_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sd_d  = {d, sd_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bq_d  = bout;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the result together with the done pulse
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = {d, sd_q[WIDTH-1:1]};
          borrow_d = bout;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit vector table, overlap/reset/held-start
// sequences, and a 4-bit instance for held-start spacing and latency.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Issue one 8-bit op from a negedge with the DUT idle; optionally re-pulse start
  // and scramble operands mid-operation. Returns result seen with done.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit interfere,
                      output int lat, output int busy_cnt, output int done_cnt,
                      output int diff_v, output int bo_v);
    bus8.a = av; bus8.b = bv; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    lat = -1; busy_cnt = 0; done_cnt = 0; diff_v = -1; bo_v = -1;
    for (int i = 0; i < 40; i++) begin
      if (interfere && i == 2) begin
        bus8.start = 1'b1; bus8.a = 8'd1; bus8.b = 8'd2;
      end
      if (interfere && i == 3) begin
        bus8.start = 1'b0; bus8.a = 8'h55; bus8.b = 8'hAA;
      end
      if (bus8.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = i; diff_v = int'(bus8.diff); bo_v = int'(bus8.borrow_out);
        end
      end
      if (!bus8.busy) break;
      busy_cnt++;
      step();
    end
  endtask

  int lat, bcnt, dcnt, dv, bov, expd, seen;

  initial begin
    n_total = 0; n_pass = 0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    rst_n = 1'b0;

    vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
    vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
    vecs[4] = '{8'h00,  8'h01,  8'hFF,  1'b1};
    vecs[5] = '{8'hFF,  8'h00,  8'hFF,  1'b0};
    vecs[6] = '{8'd10,  8'd3,   8'd7,   1'b0};
    vecs[7] = '{8'd128, 8'd127, 8'd1,   1'b0};
    vecs[8] = '{8'd127, 8'd128, 8'd255, 1'b1};
    vecs[9] = '{8'hAA,  8'h55,  8'h55,  1'b0};

    step(); step();
    chk("rst_busy", int'(bus8.busy), 0);
    chk("rst_done", int'(bus8.done), 0);
    chk("rst_diff", int'(bus8.diff), 0);
    chk("rst_bo",   int'(bus8.borrow_out), 0);
    chk("rst_busy4", int'(bus4.busy), 0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 10; v++) begin
      run8(vecs[v].a, vecs[v].b, 1'b0, lat, bcnt, dcnt, dv, bov);
      chk($sformatf("v%0d_lat", v), lat, 8);
      chk($sformatf("v%0d_busy_cycles", v), bcnt, 9);
      chk($sformatf("v%0d_done_cnt", v), dcnt, 1);
      chk($sformatf("v%0d_diff", v), dv, int'(vecs[v].diff));
      chk($sformatf("v%0d_bo", v), bov, int'(vecs[v].bo));
      chk($sformatf("v%0d_diff_hold", v), int'(bus8.diff), int'(vecs[v].diff));
      step();
    end

    // Second start mid-operation and operand changes are ignored
    run8(8'd200, 8'd50, 1'b1, lat, bcnt, dcnt, dv, bov);
    chk("ovl_done_cnt", dcnt, 1);
    chk("ovl_diff", dv, 150);
    chk("ovl_bo", bov, 0);
    step(); step();
    chk("ovl_no_queue", int'(bus8.busy), 0);

    // Asynchronous reset mid-operation
    bus8.a = 8'd20; bus8.b = 8'd1; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus8.busy), 0);
    chk("arst_done", int'(bus8.done), 0);
    chk("arst_diff", int'(bus8.diff), 0);
    chk("arst_bo",   int'(bus8.borrow_out), 0);
    step();
    rst_n = 1'b1;
    step();
    run8(8'd20, 8'd1, 1'b0, lat, bcnt, dcnt, dv, bov);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_diff", dv, 19);
    chk("post_rst_bo", bov, 0);
    step();

    // Held start: done every WIDTH+2 edges
    bus8.a = 8'd7; bus8.b = 8'd7; bus8.start = 1'b1;
    expd = 9; seen = 0;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (bus8.done) begin
        seen++;
        chk("hold8_done_pos", i, expd);
        chk("hold8_diff", int'(bus8.diff), 0);
        chk("hold8_bo", int'(bus8.borrow_out), 0);
        expd += 10;
      end
    end
    chk("hold8_done_cnt", seen, 3);
    bus8.start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("hold8_idle", int'(bus8.busy), 0);

    // 4-bit instance: latency 4, spacing 6
    bus4.a = 4'd3; bus4.b = 4'd4; bus4.start = 1'b1;
    expd = 5; seen = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) chk("w4_busy_first", int'(bus4.busy), 1);
      if (bus4.done) begin
        seen++;
        chk("w4_done_pos", i, expd);
        chk("w4_diff", int'(bus4.diff), 15);
        chk("w4_bo", int'(bus4.borrow_out), 1);
        expd += 6;
      end
    end
    chk("w4_done_cnt", seen, 3);
    bus4.start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("w4_idle", int'(bus4.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
